// File: rtl/baby_stress_model.sv
// baby_stress_model: behavioural cradle/baby stand-in for the A/F controller.
// Amplitude A and frequency F are registered every cycle. Once they have been stable
// for a full evaluation window, the stress level moves by the distance from the
// comfort point, minus 4. A one-cycle stressGezakt pulse reports each decrease.
// err freezes the window counter for as long as it is high.
module baby_stress_model #(
    parameter int PERIOD      = 1000,
    parameter int TARGET_A    = 5,
    parameter int TARGET_F    = 3,
    parameter int STRESS_INIT = 200,
    parameter int STRESS_MAX  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] A,
    input  logic [2:0] F,
    input  logic       err,
    output logic       stressGezakt,
    output logic [7:0] stress,
    output logic       calm
);

    localparam int                 CW    = $clog2(PERIOD);
    localparam logic [CW-1:0]      LAST  = CW'(PERIOD - 1);
    localparam logic [2:0]         TA    = 3'(TARGET_A);
    localparam logic [2:0]         TF    = 3'(TARGET_F);
    localparam logic signed [9:0]  SMAX  = 10'(STRESS_MAX);
    localparam logic [7:0]         SINIT = 8'(STRESS_INIT);

    typedef enum logic {S_RUN, S_HOLD} state_t;

    logic [2:0]        r_a_q, r_f_q;
    logic [CW-1:0]     r_cnt;
    state_t            r_state;
    logic [7:0]        r_stress;
    logic              r_pulse;
    logic              r_calm;

    logic              w_chg;
    logic              w_tick;
    logic [2:0]        w_da, w_df;
    logic [3:0]        w_d;
    logic signed [9:0] w_n;
    logic [7:0]        w_next;
    logic              w_dec;

    // Any difference from last cycle's sample restarts the window.
    assign w_chg  = (A != r_a_q) | (F != r_f_q);
    // A tick needs stable inputs, no error and a completed window.
    assign w_tick = ~w_chg & ~err & (r_cnt == LAST);

    // Distance from the comfort point uses the stable, registered inputs.
    assign w_da = (r_a_q >= TA) ? (r_a_q - TA) : (TA - r_a_q);
    assign w_df = (r_f_q >= TF) ? (r_f_q - TF) : (TF - r_f_q);
    assign w_d  = {1'b0, w_da} + {1'b0, w_df};
    assign w_n  = $signed({2'b00, r_stress}) + $signed({6'b000000, w_d}) - 10'sd4;

    // Clamp the candidate stress into [0, STRESS_MAX].
    always_comb begin
        w_next = w_n[7:0];
        if (w_n < 10'sd0)
            w_next = 8'd0;
        else if (w_n > SMAX)
            w_next = SMAX[7:0];
    end

    assign w_dec = (w_next < r_stress);

    // Input sample registers, used for change detection and for the evaluation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_q <= 3'd0;
            r_f_q <= 3'd0;
        end else begin
            r_a_q <= A;
            r_f_q <= F;
        end
    end

    // Window counter, RUN/HOLD state and the registered stress/flag outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_state  <= S_RUN;
            r_stress <= SINIT;
            r_pulse  <= 1'b0;
            r_calm   <= (STRESS_INIT == 0);
        end else begin
            case (r_state)
                S_RUN:   if (err)  r_state <= S_HOLD;
                S_HOLD:  if (!err) r_state <= S_RUN;
                default: r_state <= S_RUN;
            endcase

            // Change beats error, and error beats window completion.
            if (w_chg)
                r_cnt <= '0;
            else if (err)
                r_cnt <= r_cnt;
            else if (r_cnt == LAST)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);

            r_pulse <= w_tick & w_dec;
            if (w_tick) begin
                r_stress <= w_next;
                r_calm   <= (w_next == 8'd0);
            end
        end
    end

    // A tick always moves the state to RUN, so a pulse is never visible in HOLD.
    assign stressGezakt = r_pulse & (r_state == S_RUN);
    assign stress       = r_stress;
    assign calm         = r_calm;

endmodule

// File: tb/tb_baby_stress_model.sv
// Bench for baby_stress_model: three instances with initial stress 200, 250 and 6 share
// the same stimulus. A window/distance model checks every output on every cycle.
// Literal values at the scripted points pin that model.
module tb_baby_stress_model;

    localparam int P = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] A = 3'd0;
    logic [2:0] F = 3'd0;
    logic       err = 1'b0;

    logic       sg0, sg1, sg2, cm0, cm1, cm2;
    logic [7:0] st0, st1, st2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    baby_stress_model #(.PERIOD(P), .STRESS_INIT(200)) u0 (
        .clk(clk), .reset(reset), .A(A), .F(F), .err(err),
        .stressGezakt(sg0), .stress(st0), .calm(cm0));
    baby_stress_model #(.PERIOD(P), .STRESS_INIT(250)) u1 (
        .clk(clk), .reset(reset), .A(A), .F(F), .err(err),
        .stressGezakt(sg1), .stress(st1), .calm(cm1));
    baby_stress_model #(.PERIOD(P), .STRESS_INIT(6)) u2 (
        .clk(clk), .reset(reset), .A(A), .F(F), .err(err),
        .stressGezakt(sg2), .stress(st2), .calm(cm2));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: count stable, error-free cycles since the last input change.
    // Every PERIOD of them is an evaluation.
    int m_init[3] = '{200, 250, 6};
    int m_st[3];
    int m_p[3];
    int m_since;
    int m_pa, m_pf;

    initial begin
        for (int i = 0; i < 3; i++) begin m_st[i] = m_init[i]; m_p[i] = 0; end
        m_since = 0; m_pa = 0; m_pf = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int i = 0; i < 3; i++) begin m_st[i] = m_init[i]; m_p[i] = 0; end
                m_since = 0; m_pa = 0; m_pf = 0;
            end else begin
                bit tick;
                int da, df, n;
                tick = 0;
                if (int'(A) != m_pa || int'(F) != m_pf) m_since = 0;
                else if (!err) begin
                    m_since++;
                    if (m_since == P) begin tick = 1; m_since = 0; end
                end
                m_pa = int'(A); m_pf = int'(F);
                da = int'(A) - 5; if (da < 0) da = -da;
                df = int'(F) - 3; if (df < 0) df = -df;
                for (int i = 0; i < 3; i++) begin
                    m_p[i] = 0;
                    if (tick) begin
                        n = m_st[i] + da + df - 4;
                        if (n < 0) n = 0;
                        if (n > 255) n = 255;
                        m_p[i] = (n < m_st[i]) ? 1 : 0;
                        m_st[i] = n;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("u0.stress", st0, m_st[0]);
            chk("u0.pulse",  sg0, m_p[0]);
            chk("u0.calm",   cm0, m_st[0] == 0);
            chk("u1.stress", st1, m_st[1]);
            chk("u1.pulse",  sg1, m_p[1]);
            chk("u1.calm",   cm1, m_st[1] == 0);
            chk("u2.stress", st2, m_st[2]);
            chk("u2.pulse",  sg2, m_p[2]);
            chk("u2.calm",   cm2, m_st[2] == 0);
        end
    end

    initial begin
        // Reset held low for 3 cycles.
        cyc(3);
        chk("rst.stress0", st0, 200);
        chk("rst.stress1", st1, 250);
        chk("rst.pulse0", sg0, 0);
        chk("rst.calm0", cm0, 0);

        // Comfort point: -4 per tick, the first tick 8 cycles after the change.
        reset = 1'b1; A = 3'd5; F = 3'd3;
        cyc(9);
        chk("comfort.t1", st0, 196);
        chk("comfort.t1.pulse", sg0, 1);
        cyc(1);
        chk("comfort.width", sg0, 0);
        cyc(7);
        chk("comfort.t2", st0, 192);
        cyc(8);
        chk("comfort.t3", st0, 188);
        chk("calm.u2", st2, 0);
        chk("calm.u2.flag", cm2, 1);
        chk("comfort.u1", st1, 238);

        // Off target (d = 8): +4 per tick, saturating at 255.
        A = 3'd0; F = 3'd0;
        cyc(1 + 4 * P);
        chk("off.254", st1, 254);
        cyc(P);
        chk("off.sat", st1, 255);
        chk("off.sat.pulse", sg1, 0);
        cyc(P);
        chk("off.sat2", st1, 255);
        chk("off.u0", st0, 212);
        chk("off.u2", st2, 24);

        // Near target: d = 1 drops by 3, d = 4 stays put.
        A = 3'd4; F = 3'd3;
        cyc(1 + 2 * P);
        chk("near.d1", st0, 206);
        A = 3'd1;
        cyc(1 + 2 * P);
        chk("near.d4", st0, 206);

        // Unstable input: a change every 5 cycles never lets a window finish.
        for (int k = 0; k < 8; k++) begin
            A = (k % 2 == 0) ? 3'd4 : 3'd5;
            cyc(5);
        end
        chk("unstable.hold", st0, 206);
        A = 3'd4;
        cyc(5);
        A = 3'd5;
        cyc(P);
        chk("unstable.pre", st0, 206);
        cyc(1);
        chk("unstable.tick", st0, 202);
        chk("unstable.pulse", sg0, 1);

        // err for 4 cycles mid-window delays the tick by 4.
        cyc(3);
        err = 1'b1;
        cyc(4);
        err = 1'b0;
        cyc(4);
        chk("err.pre", st0, 202);
        cyc(1);
        chk("err.tick", st0, 198);
        chk("err.pulse", sg0, 1);

        // Reset mid-window is asynchronous.
        cyc(3);
        #2 reset = 1'b0;
        #1;
        chk("midrst.stress", st0, 200);
        chk("midrst.pulse", sg0, 0);
        cyc(2);
        reset = 1'b1;
        cyc(9);
        chk("pulse.before.rst", sg0, 1);
        #1 reset = 1'b0;
        #1;
        chk("midpulse.pulse", sg0, 0);
        chk("midpulse.stress", st0, 200);
        cyc(2);
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(15) == 0) begin
                A = 3'($urandom_range(7));
                F = 3'($urandom_range(7));
            end
            err = ($urandom_range(9) == 0);
            cyc(1);
        end
        err = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
